// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin switch allocator with packet-granular locks
// Each output is IDLE or LOCKED to one input; the lock is released by a transferred tail flit.
module switch_allocator #(
  parameter int N_PORTS = 5,
  parameter int SEL_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         req_valid,
  input  logic [N_PORTS-1:0]         req_head,
  input  logic [N_PORTS-1:0]         req_tail,
  input  logic [N_PORTS*N_PORTS-1:0] req_dest,
  input  logic [N_PORTS-1:0]         out_ready,
  output logic [N_PORTS-1:0]         grant,
  output logic [N_PORTS-1:0]         xfer,
  output logic [N_PORTS*SEL_W-1:0]   xbar_sel,
  output logic                       dest_err
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t             r_state     [N_PORTS];
  logic [SEL_W-1:0]   r_owner     [N_PORTS];
  logic [SEL_W-1:0]   r_last      [N_PORTS];
  logic               r_dest_err;

  state_t             w_state_nxt [N_PORTS];
  logic [SEL_W-1:0]   w_owner_nxt [N_PORTS];
  logic [SEL_W-1:0]   w_last_nxt  [N_PORTS];
  logic [N_PORTS-1:0] w_release;
  logic [N_PORTS-1:0] w_onehot;
  logic [N_PORTS-1:0] w_taken;
  logic               w_found;
  int                 w_idx;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      w_onehot[i] = $onehot(req_dest[N_PORTS*i +: N_PORTS]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < N_PORTS; o++) begin
        r_state[o] <= S_IDLE;
        r_owner[o] <= '0;
        r_last[o]  <= SEL_W'(N_PORTS - 1);
      end
      r_dest_err <= 1'b0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_last[o]  <= w_last_nxt[o];
      end
      r_dest_err <= |(req_valid & req_head & ~w_onehot);
    end
  end

  // Grant and select come only from state; xfer is the one path from the request inputs.
  always_comb begin
    grant     = '0;
    xfer      = '0;
    w_release = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      xbar_sel[SEL_W*o +: SEL_W] = (r_state[o] == S_LOCKED) ? r_owner[o] : '1;
      if (r_state[o] == S_LOCKED) begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (r_owner[o] == SEL_W'(i)) begin
            grant[i]     = 1'b1;
            xfer[i]      = xfer[i] | (req_valid[i] & out_ready[o]);
            w_release[o] = req_valid[i] & out_ready[o] & req_tail[i];
          end
        end
      end
    end
  end

  // w_taken keeps a lower-numbered output's winner away from higher outputs in the same cycle.
  always_comb begin
    w_taken = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int o = 0; o < N_PORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_last_nxt[o]  = r_last[o];
      if (r_state[o] == S_LOCKED) begin
        if (w_release[o]) begin
          w_state_nxt[o] = S_IDLE;
        end
      end else begin
        w_found = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
          w_idx = (int'(r_last[o]) + k) % N_PORTS;
          if (!w_found && req_valid[w_idx] && req_head[w_idx] && w_onehot[w_idx] &&
              req_dest[N_PORTS*w_idx + o] && !grant[w_idx] && !w_taken[w_idx]) begin
            w_found        = 1'b1;
            w_state_nxt[o] = S_LOCKED;
            w_owner_nxt[o] = SEL_W'(w_idx);
            w_last_nxt[o]  = SEL_W'(w_idx);
            w_taken[w_idx] = 1'b1;
          end
        end
      end
    end
  end

  assign dest_err = r_dest_err;

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed and randomized checks of switch_allocator against a reference model
module tb_switch_allocator;
  localparam int N  = 5;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_head, req_tail, out_ready;
  logic [N*N-1:0]  req_dest;
  logic [N-1:0]    grant, xfer;
  logic [N*SW-1:0] xbar_sel;
  logic            dest_err;

  int total = 0;
  int bad   = 0;

  int m_lock [N];
  int m_own  [N];
  int m_last [N];
  bit m_err;

  int order_q [$];

  switch_allocator #(.N_PORTS(N), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_head(req_head),
    .req_tail(req_tail), .req_dest(req_dest), .out_ready(out_ready),
    .grant(grant), .xfer(xfer), .xbar_sel(xbar_sel), .dest_err(dest_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dest_ok(input int i);
    logic [N-1:0] f;
    f = req_dest[N*i +: N];
    return $countones(f) == 1;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_lock[o] = 0;
      m_own[o]  = 0;
      m_last[o] = N - 1;
    end
    m_err = 0;
  endtask

  task automatic check_all();
    logic [N-1:0]    eg, ex;
    logic [N*SW-1:0] es;
    eg = '0;
    ex = '0;
    es = '1;
    for (int o = 0; o < N; o++) begin
      if (m_lock[o] != 0) begin
        eg[m_own[o]] = 1'b1;
        es[SW*o +: SW] = SW'(m_own[o]);
        if (req_valid[m_own[o]] && out_ready[o]) ex[m_own[o]] = 1'b1;
      end
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("xfer", 32'(xfer), 32'(ex));
    chk("xbar_sel", 32'(xbar_sel), 32'(es));
    chk("dest_err", 32'(dest_err), 32'(m_err));
  endtask

  // Arbitration picks the candidate nearest after last[o] in circular distance.
  task automatic model_edge();
    int nl [N];
    int no [N];
    int nla [N];
    bit owns [N];
    bit taken [N];
    int best, bestd, d, i;
    bit e;
    for (int k = 0; k < N; k++) begin
      owns[k]  = 0;
      taken[k] = 0;
    end
    for (int o = 0; o < N; o++) if (m_lock[o] != 0) owns[m_own[o]] = 1;
    for (int o = 0; o < N; o++) begin
      nl[o] = m_lock[o]; no[o] = m_own[o]; nla[o] = m_last[o];
      if (m_lock[o] != 0) begin
        i = m_own[o];
        if (req_valid[i] && out_ready[o] && req_tail[i]) nl[o] = 0;
      end else begin
        best = -1;
        bestd = N;
        for (int c = 0; c < N; c++) begin
          if (req_valid[c] && req_head[c] && dest_ok(c) && req_dest[N*c + o] && !owns[c] && !taken[c]) begin
            d = (c - m_last[o] - 1 + 2 * N) % N;
            if (d < bestd) begin
              bestd = d;
              best = c;
            end
          end
        end
        if (best >= 0) begin
          nl[o] = 1; no[o] = best; nla[o] = best; taken[best] = 1;
        end
      end
    end
    e = 0;
    for (int c = 0; c < N; c++) if (req_valid[c] && req_head[c] && !dest_ok(c)) e = 1;
    for (int o = 0; o < N; o++) begin
      m_lock[o] = nl[o]; m_own[o] = no[o]; m_last[o] = nla[o];
    end
    m_err = e;
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    req_valid = '0; req_head = '0; req_tail = '0; req_dest = '0; out_ready = '1;
  endtask

  task automatic flit(input int i, input bit h, input bit t, input int o);
    logic [N-1:0] oh;
    oh = N'(1) << o;
    req_valid[i] = 1'b1;
    req_head[i]  = h;
    req_tail[i]  = t;
    req_dest[N*i +: N] = oh;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_xbar", 32'(xbar_sel), 32'hFFFFF);
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int k, cyc, pulses;
    bit s;
    reset = 1'b0;
    idle_in();
    model_reset();
    @(negedge clk);
    #1 check_all();
    chk("reset_xbar", 32'(xbar_sel), 32'hFFFFF);
    @(negedge clk);
    reset = 1'b1;

    // single-flit packet from input 0 to output 2
    flit(0, 1, 1, 2);
    step();
    #1;
    chk("sf_grant0", 32'(grant[0]), 32'h1);
    chk("sf_sel2", 32'(xbar_sel[SW*2 +: SW]), 32'h0);
    chk("sf_xfer0", 32'(xfer[0]), 32'h1);
    step();
    idle_in();
    #1 chk("sf_sel2_idle", 32'(xbar_sel[SW*2 +: SW]), 32'hF);
    step();

    // three inputs contend for output 0
    flit(1, 1, 1, 0); flit(3, 1, 1, 0); flit(4, 1, 1, 0);
    for (int c = 0; c < 8; c++) begin
      step();
      #1 if (xbar_sel[SW-1:0] != 4'hF) order_q.push_back(int'(xbar_sel[SW-1:0]));
    end
    chk("rr_count", 32'(order_q.size()), 32'd4);
    if (order_q.size() == 4) begin
      chk("rr_0", 32'(order_q[0]), 32'd1);
      chk("rr_1", 32'(order_q[1]), 32'd3);
      chk("rr_2", 32'(order_q[2]), 32'd4);
      chk("rr_3", 32'(order_q[3]), 32'd1);
    end
    idle_in();
    step();

    // 4-flit packet with a 3-cycle stall on output 1
    k = 0; cyc = 0; pulses = 0;
    while (k < 4 && cyc < 20) begin
      idle_in();
      flit(2, k == 0, k == 3, 1);
      out_ready[1] = !(cyc >= 3 && cyc <= 5);
      #1 s = xfer[2];
      if (cyc >= 3 && cyc <= 5) begin
        chk("stall_xfer", 32'(xfer[2]), 32'h0);
        chk("stall_grant", 32'(grant[2]), 32'h1);
      end
      step();
      if (s) begin
        k++;
        pulses++;
      end
      cyc++;
    end
    chk("pkt_pulses", 32'(pulses), 32'd4);
    chk("pkt_cycles", 32'(cyc), 32'd8);
    idle_in();
    #1 chk("pkt_idle", 32'(xbar_sel[SW*1 +: SW]), 32'hF);
    step();

    // all five inputs to distinct outputs
    for (int i = 0; i < N; i++) flit(i, 1, 1, i);
    step();
    #1;
    chk("all_grant", 32'(grant), 32'h1F);
    chk("all_sel", 32'(xbar_sel), 32'h43210);
    step();
    idle_in();
    step();

    // malformed destination
    req_valid[0] = 1'b1; req_head[0] = 1'b1; req_tail[0] = 1'b1; req_dest[N-1:0] = 5'b00110;
    step();
    #1;
    chk("derr_pulse", 32'(dest_err), 32'h1);
    chk("derr_grant", 32'(grant), 32'h0);
    idle_in();
    step();
    #1 chk("derr_clear", 32'(dest_err), 32'h0);

    // reset during a locked packet on output 3
    flit(1, 1, 0, 3);
    step();
    step();
    req_head[1] = 1'b0;
    step();
    async_reset();
    idle_in();
    flit(0, 1, 1, 3); flit(4, 1, 1, 3);
    step();
    #1 chk("rst_rr_sel3", 32'(xbar_sel[SW*3 +: SW]), 32'h0);
    step();
    idle_in();
    step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_head  = N'($urandom);
      req_tail  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 8) req_dest[N*i +: N] = N'(1) << $urandom_range(0, N - 1);
        else req_dest[N*i +: N] = N'($urandom);
      end
      for (int o = 0; o < N; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
